// File: rtl/mem_bus_bridge_pkg.sv
// Shared definitions for the bridge between the control FSM memory strobes and the external bus.
package mem_bus_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_bridge_state_t;

    localparam int         MEM_BRIDGE_TIMEOUT_DEFAULT = 255;
    localparam logic [7:0] MEM_BRIDGE_ERR_DATA        = 8'hFF;

endpackage

// File: rtl/mem_timeout_counter.sv
// Wait-state counter for the memory bus bridge; flags the WAIT cycle in which the limit is reached.
module mem_timeout_counter #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    logic [7:0] count_q;

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count_q <= '0;
        else if (clear)
            count_q <= '0;
        else if (count_en)
            count_q <= count_q + 8'd1;
    end

    // Expiry is flagged on the cycle whose increment would reach LIMIT, so WAIT lasts exactly LIMIT cycles.
    assign expired = count_en && (count_q == 8'(LIMIT - 1));

endmodule

// File: rtl/mem_bus_bridge.sv
// Turns the control FSM's single-cycle memory strobes into a req/ack external bus transaction.
// Define MEM_BRIDGE_TIMEOUT_EN to abort transactions after TIMEOUT_CYCLES wait cycles.
module mem_bus_bridge
    import mem_bus_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = MEM_BRIDGE_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        address_read,
    input  logic [15:0] addr_bus_i,
    input  logic        mem_enable,
    input  logic        data_in,
    input  logic        data_out,
    input  logic [7:0]  wdata_i,
    output logic [7:0]  rdata_o,
    output logic        rdata_valid_o,
    output logic        hold_o,
    output logic        bus_err_o,
    output logic        ext_req_o,
    output logic        ext_we_o,
    output logic [15:0] ext_addr_o,
    output logic [7:0]  ext_wdata_o,
    input  logic        ext_ack_i,
    input  logic [7:0]  ext_rdata_i
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mem_bus_bridge: TIMEOUT_CYCLES must be within 1..255");
    end

    mem_bridge_state_t state;
    logic [15:0]       addr_q;
    logic              accept;
    logic              expired;

    assign accept = (state == IDLE) && mem_enable && (data_in || data_out);

    // The FSM must freeze in the accept cycle itself, before the state register has moved.
    assign hold_o = !rst && ((state == WAIT) || accept);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            addr_q        <= '0;
            ext_req_o     <= 1'b0;
            ext_we_o      <= 1'b0;
            ext_addr_o    <= '0;
            ext_wdata_o   <= '0;
            rdata_o       <= '0;
            rdata_valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (address_read)
                        addr_q <= addr_bus_i;
                    if (accept) begin
                        ext_addr_o  <= address_read ? addr_bus_i : addr_q;
                        ext_we_o    <= data_out;
                        ext_wdata_o <= wdata_i;
                        ext_req_o   <= 1'b1;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (ext_ack_i || expired) begin
                        if (!ext_we_o)
                            rdata_o <= ext_ack_i ? ext_rdata_i : MEM_BRIDGE_ERR_DATA;
                        rdata_valid_o <= !ext_we_o;
                        ext_req_o     <= 1'b0;
                        state         <= RESP;
                    end
                end
                default: begin
                    // RESP: the FSM's still-asserted strobes belong to the finished step.
                    rdata_valid_o <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_BRIDGE_TIMEOUT_EN
    logic bus_err_q;

    mem_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .count_en ((state == WAIT) && !ext_ack_i),
        .expired  (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bus_err_q <= 1'b0;
        else if ((state == WAIT) && expired)
            bus_err_q <= 1'b1;
    end

    assign bus_err_o = bus_err_q;
`else
    assign expired   = 1'b0;
    assign bus_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Self-checking bench for mem_bus_bridge: transaction-level model plus directed vectors.
module tb_mem_bus_bridge;

    localparam int TMO = 4;
`ifdef MEM_BRIDGE_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        address_read = 1'b0;
    logic [15:0] addr_bus_i = '0;
    logic        mem_enable = 1'b0;
    logic        data_in = 1'b0;
    logic        data_out = 1'b0;
    logic [7:0]  wdata_i = '0;
    logic        ext_ack_i = 1'b0;
    logic [7:0]  ext_rdata_i = '0;
    logic [7:0]  rdata_o;
    logic        rdata_valid_o, hold_o, bus_err_o, ext_req_o, ext_we_o;
    logic [15:0] ext_addr_o;
    logic [7:0]  ext_wdata_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_bus_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .address_read  (address_read),
        .addr_bus_i    (addr_bus_i),
        .mem_enable    (mem_enable),
        .data_in       (data_in),
        .data_out      (data_out),
        .wdata_i       (wdata_i),
        .rdata_o       (rdata_o),
        .rdata_valid_o (rdata_valid_o),
        .hold_o        (hold_o),
        .bus_err_o     (bus_err_o),
        .ext_req_o     (ext_req_o),
        .ext_we_o      (ext_we_o),
        .ext_addr_o    (ext_addr_o),
        .ext_wdata_o   (ext_wdata_o),
        .ext_ack_i     (ext_ack_i),
        .ext_rdata_i   (ext_rdata_i)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: an outstanding access, a one-step completion, and the visible data.
    bit          m_busy = 0, m_resp = 0, m_we = 0, m_err = 0;
    logic [15:0] m_addr_q = '0, m_addr = '0;
    logic [7:0]  m_wdata = '0, m_rdata = '0;
    int          m_waits = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_resp = 0; m_we = 0; m_err = 0;
            m_addr_q = '0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_waits = 0;
        end else if (m_resp) begin
            m_resp = 0;
        end else if (m_busy) begin
            if (ext_ack_i) begin
                m_busy = 0; m_resp = 1;
                if (!m_we) m_rdata = ext_rdata_i;
            end else begin
                m_waits++;
                if (TMO_EN && m_waits == TMO) begin
                    m_busy = 0; m_resp = 1; m_err = 1;
                    if (!m_we) m_rdata = 8'hFF;
                end
            end
        end else begin
            if (mem_enable && (data_in || data_out)) begin
                m_addr  = address_read ? addr_bus_i : m_addr_q;
                m_we    = data_out;
                m_wdata = wdata_i;
                m_busy  = 1;
                m_waits = 0;
            end
            if (address_read) m_addr_q = addr_bus_i;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("req", ext_req_o, m_busy);
            check("hold", hold_o, m_busy || (!m_resp && mem_enable && (data_in || data_out)));
            check("rvalid", rdata_valid_o, m_resp && !m_we);
            check("rdata", rdata_o, m_rdata);
            check("err", bus_err_o, m_err);
            if (m_busy) begin
                check("ext_addr", ext_addr_o, m_addr);
                check("ext_we", ext_we_o, m_we);
                check("ext_wdata", ext_wdata_o, m_wdata);
            end
        end
    end

    // Drives one FSM memory step; cycle c=0 is the accept cycle. ack_at < 0 means no ack.
    task automatic txn(input logic ar, input logic [15:0] a, input logic rd, input logic wr,
                       input logic [7:0] wd, input int ack_at, input logic [7:0] ack_data,
                       input int en_len, input int len,
                       output int holds, output int reqs, output int valids,
                       output logic [15:0] seen_addr, output logic seen_we,
                       output logic [7:0] seen_wd, output logic [7:0] resp_data);
        logic prev_req;
        prev_req = 1'b0;
        holds = 0; reqs = 0; valids = 0;
        seen_addr = '0; seen_we = 1'b0; seen_wd = '0; resp_data = '0;
        for (int c = 0; c < len; c++) begin
            address_read = ar && (c == 0);
            addr_bus_i   = a;
            mem_enable   = (c < en_len);
            data_in      = rd && (c < en_len);
            data_out     = wr && (c < en_len);
            wdata_i      = wd;
            ext_ack_i    = (c == ack_at);
            ext_rdata_i  = (c == ack_at) ? ack_data : 8'h00;
            @(negedge clk);
            if (hold_o) holds++;
            if (ext_req_o && !prev_req) begin
                reqs++;
                seen_addr = ext_addr_o;
                seen_we   = ext_we_o;
                seen_wd   = ext_wdata_o;
            end
            prev_req = ext_req_o;
            if (rdata_valid_o) begin
                valids++;
                resp_data = rdata_o;
            end
            @(posedge clk);
            #1;
        end
        address_read = 0; mem_enable = 0; data_in = 0; data_out = 0;
        ext_ack_i = 0; ext_rdata_i = '0;
    endtask

    initial begin
        int          holds, reqs, valids;
        logic [15:0] sa;
        logic        sw;
        logic [7:0]  swd, sr;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", ext_req_o, 0);
        check("rst_hold", hold_o, 0);
        check("rst_rvalid", rdata_valid_o, 0);
        check("rst_rdata", rdata_o, 8'h00);
        check("rst_err", bus_err_o, 0);
        check("rst_addr", ext_addr_o, 16'h0000);
        check("rst_we", ext_we_o, 0);
        @(posedge clk);
        #1;
        rst = 0;

        // Read with address bypass, ack three cycles after accept
        txn(1, 16'h1234, 1, 0, 8'h00, 3, 8'h5A, 5, 6, holds, reqs, valids, sa, sw, swd, sr);
        check("rd_holds", holds, 4);
        check("rd_reqs", reqs, 1);
        check("rd_addr", sa, 16'h1234);
        check("rd_we", sw, 0);
        check("rd_valids", valids, 1);
        check("rd_data", sr, 8'h5A);

        // Write from latched address, zero-wait ack; addr_bus_i shows a decoy value
        address_read = 1; addr_bus_i = 16'h00FF;
        @(posedge clk);
        #1;
        address_read = 0;
        txn(0, 16'hBEEF, 0, 1, 8'hC3, 1, 8'h00, 3, 4, holds, reqs, valids, sa, sw, swd, sr);
        check("wr_holds", holds, 2);
        check("wr_reqs", reqs, 1);
        check("wr_addr", sa, 16'h00FF);
        check("wr_we", sw, 1);
        check("wr_wdata", swd, 8'hC3);
        check("wr_valids", valids, 0);

        // Both directions: write wins; strobes held through RESP
        txn(1, 16'hA5A5, 1, 1, 8'h3C, 2, 8'h77, 4, 6, holds, reqs, valids, sa, sw, swd, sr);
        check("ww_holds", holds, 3);
        check("ww_reqs", reqs, 1);
        check("ww_we", sw, 1);
        check("ww_valids", valids, 0);
        check("ww_rdata_kept", rdata_o, 8'h5A);

        // mem_enable without direction is ignored
        mem_enable = 1;
        @(negedge clk);
        check("nodir_hold", hold_o, 0);
        @(posedge clk);
        #1;
        mem_enable = 0;
        @(negedge clk);
        check("nodir_req", ext_req_o, 0);

        // Ack while idle is ignored
        @(posedge clk);
        #1;
        ext_ack_i = 1; ext_rdata_i = 8'h99;
        @(negedge clk);
        check("idle_ack_valid", rdata_valid_o, 0);
        @(posedge clk);
        #1;
        ext_ack_i = 0; ext_rdata_i = '0;
        @(negedge clk);
        check("idle_ack_rdata", rdata_o, 8'h5A);
        check("idle_ack_valid2", rdata_valid_o, 0);

        // Asynchronous reset in WAIT, then a stale ack
        @(posedge clk);
        #1;
        address_read = 1; addr_bus_i = 16'h4321; mem_enable = 1; data_in = 1;
        @(posedge clk);
        #1;
        address_read = 0;
        @(posedge clk);
        #2;
        check("pre_rst_req", ext_req_o, 1);
        rst = 1;
        #1;
        check("arst_req", ext_req_o, 0);
        check("arst_hold", hold_o, 0);
        mem_enable = 0; data_in = 0;
        @(posedge clk);
        #1;
        rst = 0;
        ext_ack_i = 1; ext_rdata_i = 8'hEE;
        @(negedge clk);
        check("late_ack_req", ext_req_o, 0);
        check("late_ack_valid", rdata_valid_o, 0);
        @(posedge clk);
        #1;
        ext_ack_i = 0; ext_rdata_i = '0;
        @(negedge clk);
        check("late_ack_rdata", rdata_o, 8'h00);
        check("late_ack_valid2", rdata_valid_o, 0);
        @(posedge clk);
        #1;

`ifdef MEM_BRIDGE_TIMEOUT_EN
        // Read with no ack: RESP after four WAIT cycles with error data
        txn(1, 16'h2000, 1, 0, 8'h00, -1, 8'h00, 6, 7, holds, reqs, valids, sa, sw, swd, sr);
        check("tmo_holds", holds, 5);
        check("tmo_reqs", reqs, 1);
        check("tmo_valids", valids, 1);
        check("tmo_data", sr, 8'hFF);
        check("tmo_err", bus_err_o, 1);

        // Following good read keeps the sticky error
        txn(1, 16'h2001, 1, 0, 8'h00, 1, 8'h42, 3, 4, holds, reqs, valids, sa, sw, swd, sr);
        check("after_tmo_data", sr, 8'h42);
        check("after_tmo_err", bus_err_o, 1);

        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        check("err_cleared", bus_err_o, 0);
        @(posedge clk);
        #1;

        // Ack in the fourth WAIT cycle beats expiry
        txn(1, 16'h3000, 1, 0, 8'h00, 4, 8'h11, 6, 7, holds, reqs, valids, sa, sw, swd, sr);
        check("edge_holds", holds, 5);
        check("edge_data", sr, 8'h11);
        check("edge_err", bus_err_o, 0);
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
